// File: rtl/fft_peak_detector_pkg.sv
// Shared defaults, derived widths and FSM encoding for the FFT peak detector.
package fft_pkg;

    localparam int unsigned DATA_W_DEF  = 14;
    localparam int unsigned FFT_LEN_DEF = 1024;
    localparam int unsigned BIN_W       = $clog2(FFT_LEN_DEF);
    localparam int unsigned POW_W       = 2 * DATA_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Bin index width for a given transform length.
    function automatic int unsigned bin_width(input int unsigned len);
        return $clog2(len);
    endfunction

    // re^2 + im^2 never overflows one extra bit over the square width.
    function automatic int unsigned pow_width(input int unsigned dw);
        return 2 * dw + 1;
    endfunction

endpackage

// File: rtl/fft_peak_detector_if.sv
// FFT source stream (Avalon-ST) plus peak-result signals of the detector.
interface fft_peak_detector_if #(
    parameter int unsigned DATA_W  = fft_pkg::DATA_W_DEF,
    parameter int unsigned FFT_LEN = fft_pkg::FFT_LEN_DEF
);
    import fft_pkg::*;

    localparam int unsigned BinW = bin_width(FFT_LEN);
    localparam int unsigned PowW = pow_width(DATA_W);

    logic                     src_valid;
    logic                     src_sop;
    logic                     src_eop;
    logic [1:0]               src_error;
    logic signed [DATA_W-1:0] src_real;
    logic signed [DATA_W-1:0] src_imag;
    logic                     src_ready;
    logic                     peak_valid;
    logic [BinW-1:0]          peak_bin;
    logic [PowW-1:0]          peak_power;
    logic                     frame_error;

    // FFT core / environment side.
    modport master (
        output src_valid, src_sop, src_eop, src_error, src_real, src_imag,
        input  src_ready, peak_valid, peak_bin, peak_power, frame_error
    );

    // Peak detector side.
    modport slave (
        input  src_valid, src_sop, src_eop, src_error, src_real, src_imag,
        output src_ready, peak_valid, peak_bin, peak_power, frame_error
    );

endinterface

// File: rtl/fft_peak_detector_cplx_mag_sq.sv
// Two-stage pipelined re^2 + im^2; valid/sop/eop/error/bin travel alongside.
module cplx_mag_sq #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_valid,
    input  logic                     i_sop,
    input  logic                     i_eop,
    input  logic [1:0]               i_error,
    input  logic [BIN_W-1:0]         i_bin,
    input  logic signed [DATA_W-1:0] i_real,
    input  logic signed [DATA_W-1:0] i_imag,
    output logic                     o_valid,
    output logic                     o_sop,
    output logic                     o_eop,
    output logic                     o_error,
    output logic [BIN_W-1:0]         o_bin,
    output logic [2*DATA_W:0]        o_power
);
    localparam int unsigned SqW = 2 * DATA_W;

    logic signed [SqW-1:0] w_re_ext;
    logic signed [SqW-1:0] w_im_ext;
    logic signed [SqW-1:0] w_re_sq;
    logic signed [SqW-1:0] w_im_sq;

    logic             r_s1_valid;
    logic             r_s1_sop;
    logic             r_s1_eop;
    logic             r_s1_err;
    logic [BIN_W-1:0] r_s1_bin;
    logic [SqW-1:0]   r_re_sq;
    logic [SqW-1:0]   r_im_sq;

    logic             r_s2_valid;
    logic             r_s2_sop;
    logic             r_s2_eop;
    logic             r_s2_err;
    logic [BIN_W-1:0] r_s2_bin;
    logic [SqW:0]     r_s2_power;

    // Sign-extend first so the product is computed at full square width.
    assign w_re_ext = SqW'(i_real);
    assign w_im_ext = SqW'(i_imag);
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    // S1: squares and side-band; bubbles carry valid=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_bin   <= '0;
            r_re_sq    <= '0;
            r_im_sq    <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_sop   <= i_sop;
            r_s1_eop   <= i_eop;
            r_s1_err   <= |i_error;
            r_s1_bin   <= i_bin;
            r_re_sq    <= w_re_sq;
            r_im_sq    <= w_im_sq;
        end
    end

    // S2: sum of squares (both non-negative, so zero-extend).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sop   <= 1'b0;
            r_s2_eop   <= 1'b0;
            r_s2_err   <= 1'b0;
            r_s2_bin   <= '0;
            r_s2_power <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_sop   <= r_s1_sop;
            r_s2_eop   <= r_s1_eop;
            r_s2_err   <= r_s1_err;
            r_s2_bin   <= r_s1_bin;
            r_s2_power <= {1'b0, r_re_sq} + {1'b0, r_im_sq};
        end
    end

    assign o_valid = r_s2_valid;
    assign o_sop   = r_s2_sop;
    assign o_eop   = r_s2_eop;
    assign o_error = r_s2_err;
    assign o_bin   = r_s2_bin;
    assign o_power = r_s2_power;

endmodule

// File: rtl/fft_peak_detector.sv
// Per-frame peak search over FFT output bins with framing checks.
module fft_peak_detector
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned FFT_LEN       = FFT_LEN_DEF,
    parameter bit          SKIP_DC       = 1'b1,
    parameter bit          HALF_SPECTRUM = 1'b1
) (
    input logic                clk,
    input logic                reset_n,
    fft_peak_detector_if.slave bus
);
    localparam int unsigned     BinW     = bin_width(FFT_LEN);
    localparam int unsigned     PowW     = pow_width(DATA_W);
    localparam logic [BinW-1:0] LastBin  = BinW'(FFT_LEN - 1);
    localparam logic [BinW-1:0] HalfBin  = BinW'(FFT_LEN / 2);
    localparam logic [BinW-1:0] FirstBin = BinW'(SKIP_DC);

    logic            r_ready;
    logic [BinW-1:0] r_bin_cnt;
    logic            w_accept;
    logic [BinW-1:0] w_beat_bin;

    logic            w_s2_valid;
    logic            w_s2_sop;
    logic            w_s2_eop;
    logic            w_s2_err;
    logic [BinW-1:0] w_s2_bin;
    logic [PowW-1:0] w_s2_power;
    logic            w_cand;

    state_e          r_state;
    logic [PowW-1:0] r_max;
    logic [BinW-1:0] r_best;
    logic            r_err_seen;
    logic            r_peak_valid;
    logic            r_frame_error;
    logic [BinW-1:0] r_peak_bin;
    logic [PowW-1:0] r_peak_power;

    state_e          w_state_nxt;
    logic [PowW-1:0] w_max_nxt;
    logic [BinW-1:0] w_best_nxt;
    logic            w_err_nxt;
    logic            w_pv_nxt;
    logic            w_fe_nxt;
    logic [BinW-1:0] w_pbin_nxt;
    logic [PowW-1:0] w_ppow_nxt;
    logic [PowW-1:0] w_cur_max;
    logic [BinW-1:0] w_cur_best;
    logic            w_cur_err;
    logic            w_in_frame;

    assign w_accept   = bus.src_valid && r_ready;
    assign w_beat_bin = bus.src_sop ? '0 : r_bin_cnt;

    // Ready comes up one edge after reset release; bin counter restarts on sop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready   <= 1'b0;
            r_bin_cnt <= '0;
        end else begin
            r_ready <= 1'b1;
            if (w_accept) begin
                r_bin_cnt <= w_beat_bin + BinW'(1);
            end
        end
    end

    cplx_mag_sq #(
        .DATA_W(DATA_W),
        .BIN_W (BinW)
    ) u_mag (
        .clk    (clk),
        .reset_n(reset_n),
        .i_valid(w_accept),
        .i_sop  (bus.src_sop),
        .i_eop  (bus.src_eop),
        .i_error(bus.src_error),
        .i_bin  (w_beat_bin),
        .i_real (bus.src_real),
        .i_imag (bus.src_imag),
        .o_valid(w_s2_valid),
        .o_sop  (w_s2_sop),
        .o_eop  (w_s2_eop),
        .o_error(w_s2_err),
        .o_bin  (w_s2_bin),
        .o_power(w_s2_power)
    );

    assign w_cand = (!SKIP_DC || (w_s2_bin != '0)) &&
                    (!HALF_SPECTRUM || (w_s2_bin < HalfBin));

    // S3: frame FSM, running max and framing checks for the beat leaving S2.
    always_comb begin
        w_state_nxt = (r_state == REPORT) ? IDLE : r_state;
        w_max_nxt   = r_max;
        w_best_nxt  = r_best;
        w_err_nxt   = r_err_seen;
        w_pv_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;
        w_pbin_nxt  = r_peak_bin;
        w_ppow_nxt  = r_peak_power;
        w_cur_max   = r_max;
        w_cur_best  = r_best;
        w_cur_err   = r_err_seen;
        w_in_frame  = (r_state == ACCUM);
        if (w_s2_valid) begin
            if (w_s2_sop) begin
                // A sop inside a frame aborts it; the new frame starts on this beat.
                if (w_in_frame) begin
                    w_fe_nxt = 1'b1;
                end
                w_in_frame = 1'b1;
                w_cur_max  = '0;
                w_cur_best = FirstBin;
                w_cur_err  = 1'b0;
            end
            if (w_in_frame) begin
                w_cur_err = w_cur_err | w_s2_err;
                // Strict compare keeps the lowest bin on ties.
                if (w_cand && (w_s2_power > w_cur_max)) begin
                    w_cur_max  = w_s2_power;
                    w_cur_best = w_s2_bin;
                end
                if (w_s2_eop) begin
                    if ((w_s2_bin == LastBin) && !w_cur_err) begin
                        w_pv_nxt    = 1'b1;
                        w_pbin_nxt  = w_cur_best;
                        w_ppow_nxt  = w_cur_max;
                        w_state_nxt = REPORT;
                    end else begin
                        w_fe_nxt    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else if (w_s2_bin == LastBin) begin
                    w_fe_nxt    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = ACCUM;
                end
                w_max_nxt  = w_cur_max;
                w_best_nxt = w_cur_best;
                w_err_nxt  = w_cur_err;
            end
        end
    end

    // S3 state and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_max         <= '0;
            r_best        <= '0;
            r_err_seen    <= 1'b0;
            r_peak_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_peak_bin    <= '0;
            r_peak_power  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_max         <= w_max_nxt;
            r_best        <= w_best_nxt;
            r_err_seen    <= w_err_nxt;
            r_peak_valid  <= w_pv_nxt;
            r_frame_error <= w_fe_nxt;
            r_peak_bin    <= w_pbin_nxt;
            r_peak_power  <= w_ppow_nxt;
        end
    end

    assign bus.src_ready   = r_ready;
    assign bus.peak_valid  = r_peak_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.peak_bin    = r_peak_bin;
    assign bus.peak_power  = r_peak_power;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Scoreboard bench for fft_peak_detector: expectations are queued as frames are
// driven and matched against result strobes, including their cycle of arrival.
module tb_fft_peak_detector;

    localparam int DW = 14;
    localparam int N  = 1024;

    typedef struct {
        bit     is_err;
        int     bin;
        longint pow;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_n;
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    exp_t   sb[$];
    exp_t   mon_e;
    int     fr_re[N];
    int     fr_im[N];
    bit     pending_abort = 1'b0;
    int     exp_last_bin = 0;
    longint exp_last_pow = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_peak_detector_if #(.DATA_W(DW), .FFT_LEN(N)) bus ();

    fft_peak_detector #(
        .DATA_W       (DW),
        .FFT_LEN      (N),
        .SKIP_DC      (1'b1),
        .HALF_SPECTRUM(1'b1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Result monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.peak_valid === 1'b1 || bus.frame_error === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: peak_valid=%0b frame_error=%0b at cycle %0d, required none",
                         bus.peak_valid, bus.frame_error, cyc);
            end else begin
                mon_e = sb.pop_front();
                n_cmp++;
                if (bus.frame_error !== mon_e.is_err || bus.peak_valid !== !mon_e.is_err) begin
                    n_fail++;
                    $display("FAIL strobe_kind: peak_valid=%0b frame_error=%0b, required frame_error=%0b",
                             bus.peak_valid, bus.frame_error, mon_e.is_err);
                end
                n_cmp++;
                if (cyc !== mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL latency: strobe at cycle %0d, required %0d", cyc, mon_e.cyc);
                end
                if (!mon_e.is_err) begin
                    n_cmp++;
                    if (bus.peak_bin !== mon_e.bin) begin
                        n_fail++;
                        $display("FAIL peak_bin: got %0d, required %0d", bus.peak_bin, mon_e.bin);
                    end
                    n_cmp++;
                    if (bus.peak_power !== mon_e.pow) begin
                        n_fail++;
                        $display("FAIL peak_power: got %0d, required %0d", bus.peak_power, mon_e.pow);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        bus.src_valid = 1'b0;
        bus.src_sop   = 1'b0;
        bus.src_eop   = 1'b0;
        bus.src_error = 2'b00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input bit sop, input bit eop, input logic [1:0] err,
                              input int re, input int im);
        bus.src_valid = 1'b1;
        bus.src_sop   = sop;
        bus.src_eop   = eop;
        bus.src_error = err;
        bus.src_real  = DW'(re);
        bus.src_imag  = DW'(im);
        @(posedge clk);
        #1;
    endtask

    // Invalid cycles carry junk framing bits that must be ignored.
    task automatic bubble();
        bus.src_valid = 1'b0;
        bus.src_sop   = 1'($urandom_range(0, 1));
        bus.src_eop   = 1'($urandom_range(0, 1));
        bus.src_error = 2'($urandom_range(0, 3));
        bus.src_real  = DW'($urandom);
        bus.src_imag  = DW'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input bit with_eop, input bit gaps,
                              input int err_bin, input bit exp_err,
                              input int exp_bin, input longint exp_pow);
        exp_t e;
        for (int k = 0; k < len; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) bubble();
            end
            if (k == 0 && pending_abort) begin
                e.is_err = 1'b1; e.bin = 0; e.pow = 0; e.cyc = cyc + 3;
                sb.push_back(e);
                pending_abort = 1'b0;
            end
            if (with_eop && k == len - 1) begin
                e.is_err = exp_err; e.bin = exp_bin; e.pow = exp_pow; e.cyc = cyc + 3;
                sb.push_back(e);
                if (!exp_err) begin
                    exp_last_bin = exp_bin;
                    exp_last_pow = exp_pow;
                end
            end
            drive_beat(k == 0, with_eop && (k == len - 1),
                       (k == err_bin) ? 2'b01 : 2'b00, fr_re[k], fr_im[k]);
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Reference search: skip DC, lower half only, strictly greater wins.
    task automatic model_peak(output int bin, output longint pow);
        longint p;
        bin = 1;
        pow = 0;
        for (int k = 1; k < N / 2; k++) begin
            p = longint'(fr_re[k]) * fr_re[k] + longint'(fr_im[k]) * fr_im[k];
            if (p > pow) begin
                pow = p;
                bin = k;
            end
        end
    endtask

    task automatic fill_zero();
        for (int k = 0; k < N; k++) begin
            fr_re[k] = 0;
            fr_im[k] = 0;
        end
    endtask

    // Spectrum of a real tone at bin 10 (phi_inc 41943040) with leakage and image at 1014.
    task automatic fill_tone();
        int d;
        for (int k = 0; k < N; k++) begin
            d = (k > 10) ? k - 10 : 10 - k;
            if (((k > 1014) ? k - 1014 : 1014 - k) < d) d = (k > 1014) ? k - 1014 : 1014 - k;
            fr_re[k] = 6000 / (d + 1);
            fr_im[k] = -(3000 / (d + 2));
        end
    endtask

    task automatic check_ready_release();
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.src_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_at_release: got %b, required 0", bus.src_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.src_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b, required 1", bus.src_ready);
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.src_real  = '0;
        bus.src_imag  = '0;
        idle(3);
        n_cmp++;
        if (bus.src_ready !== 1'b0 || bus.peak_valid !== 1'b0 || bus.frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b pv=%b fe=%b, required 0 0 0",
                     bus.src_ready, bus.peak_valid, bus.frame_error);
        end
        n_cmp++;
        if (bus.peak_bin !== '0 || bus.peak_power !== '0) begin
            n_fail++;
            $display("FAIL reset_data: bin=%0d pow=%0d, required 0 0", bus.peak_bin, bus.peak_power);
        end
        check_ready_release();
    endtask

    task automatic test_tone();
        int     b;
        longint p;
        fill_tone();
        model_peak(b, p);
        send_frame(N, 1'b1, 1'b0, -1, 1'b0, b, p);
        send_frame(N, 1'b1, 1'b0, -1, 1'b0, b, p);
        drain();
    endtask

    task automatic test_directed();
        fill_zero();
        fr_re[37]  = 100;
        fr_im[37]  = -50;
        fr_re[900] = 2000;
        send_frame(N, 1'b1, 1'b0, -1, 1'b0, 37, 12500);
        drain();
    endtask

    task automatic test_tie();
        fill_zero();
        fr_re[0] = 8191; fr_im[0] = 8191;
        fr_re[5] = 300;  fr_im[5] = 400;
        fr_re[9] = 300;  fr_im[9] = 400;
        send_frame(N, 1'b1, 1'b0, -1, 1'b0, 5, 250000);
        drain();
        // All-zero frame reports the first candidate bin with zero power.
        fill_zero();
        send_frame(N, 1'b1, 1'b0, -1, 1'b0, 1, 0);
        drain();
    endtask

    task automatic test_framing();
        int     b;
        longint p;
        fill_tone();
        model_peak(b, p);
        send_frame(512, 1'b1, 1'b0, -1, 1'b1, 0, 0);
        drain();
        n_cmp++;
        if (bus.peak_bin !== exp_last_bin || bus.peak_power !== exp_last_pow) begin
            n_fail++;
            $display("FAIL hold: bin=%0d pow=%0d, required %0d %0d",
                     bus.peak_bin, bus.peak_power, exp_last_bin, exp_last_pow);
        end
        send_frame(N, 1'b1, 1'b0, -1, 1'b0, b, p);
        // Abort by sop: the partial frame errors, the new one reports.
        send_frame(300, 1'b0, 1'b0, -1, 1'b0, 0, 0);
        pending_abort = 1'b1;
        send_frame(N, 1'b1, 1'b0, -1, 1'b0, b, p);
        drain();
    endtask

    task automatic test_error_gaps();
        int     b;
        longint p;
        fill_tone();
        model_peak(b, p);
        send_frame(N, 1'b1, 1'b0, 100, 1'b1, 0, 0);
        send_frame(N, 1'b1, 1'b1, -1, 1'b0, b, p);
        drain();
    endtask

    task automatic test_reset_mid();
        int     b;
        longint p;
        fill_tone();
        model_peak(b, p);
        send_frame(401, 1'b0, 1'b0, -1, 1'b0, 0, 0);
        bus.src_valid = 1'b0;
        reset_n       = 1'b0;
        #1;
        n_cmp++;
        if (bus.src_ready !== 1'b0 || bus.peak_power !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b pow=%0d, required 0 0", bus.src_ready, bus.peak_power);
        end
        idle(3);
        check_ready_release();
        idle(4);
        send_frame(N, 1'b1, 1'b0, -1, 1'b0, b, p);
        drain();
    endtask

    initial begin
        test_reset();
        test_tone();
        test_directed();
        test_tie();
        test_framing();
        test_error_gaps();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
